// File: rtl/alu_32_bits_pkg.sv
// Shared ALU definitions: operation encoding and datapath constants.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam logic [ALU_WIDTH-1:0] DIV0_RESULT = '1;

    typedef enum logic [2:0] {
        OP_NOT = 3'd0,
        OP_OR  = 3'd1,
        OP_AND = 3'd2,
        OP_NEG = 3'd3,
        OP_ADD = 3'd4,
        OP_SUB = 3'd5,
        OP_MUL = 3'd6,
        OP_DIV = 3'd7
    } alu_op_e;

endpackage

// File: rtl/alu_32_bits_comb.sv
// Combinational ALU datapath: next result and, with ALU_FLAGS_EN, the status flags.
module alu_32_bits_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       sel_i,
    output logic [WIDTH-1:0] result_o
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             div_by_zero_o
`endif
);

    alu_op_e        op;
    logic [WIDTH:0] sum;
    logic           carry;
    logic           overflow;
    logic           div_by_zero;

    assign op = alu_op_e'(sel_i);

    always_comb begin
        result_o    = '0;
        sum         = '0;
        carry       = 1'b0;
        overflow    = 1'b0;
        div_by_zero = 1'b0;
        unique case (op)
            OP_NOT: result_o = ~a_i;
            OP_OR:  result_o = a_i | b_i;
            OP_AND: result_o = a_i & b_i;
            OP_NEG: result_o = ~a_i + 1'b1;
            OP_ADD: begin
                sum      = {1'b0, a_i} + {1'b0, b_i};
                result_o = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                // a + ~b + 1 so the carry-out is the borrow-not
                sum      = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
                result_o = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_MUL: result_o = a_i * b_i;
            OP_DIV: begin
                if (b_i == '0) begin
                    result_o    = '1;
                    div_by_zero = 1'b1;
                end else begin
                    result_o = a_i / b_i;
                end
            end
        endcase
    end

`ifdef ALU_FLAGS_EN
    assign zero_o        = (result_o == '0);
    assign carry_o       = carry;
    assign overflow_o    = overflow;
    assign div_by_zero_o = div_by_zero;
`else
    logic unused_flags;
    assign unused_flags = carry ^ overflow ^ div_by_zero ^ sum[WIDTH];
`endif

endmodule

// File: rtl/alu_32_bits.sv
// Eight-function ALU with one-cycle registered result; status flags exist only
// when ALU_FLAGS_EN is defined.
module alu_32_bits
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
`ifdef ALU_FLAGS_EN
    ,
    output logic             div_by_zero,
    output logic             zero,
    output logic             carry,
    output logic             overflow
`endif
);

    logic [WIDTH-1:0] out_d, out_q;
    logic             valid_q;

`ifdef ALU_FLAGS_EN
    logic zero_d, carry_d, overflow_d, dbz_d;
    logic zero_q, carry_q, overflow_q, dbz_q;
`endif

    alu_32_bits_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .a_i           (a),
        .b_i           (b),
        .sel_i         (sel),
        .result_o      (out_d)
`ifdef ALU_FLAGS_EN
        ,
        .zero_o        (zero_d),
        .carry_o       (carry_d),
        .overflow_o    (overflow_d),
        .div_by_zero_o (dbz_d)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            valid_q    <= 1'b0;
`ifdef ALU_FLAGS_EN
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            dbz_q      <= 1'b0;
`endif
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                out_q      <= out_d;
`ifdef ALU_FLAGS_EN
                zero_q     <= zero_d;
                carry_q    <= carry_d;
                overflow_q <= overflow_d;
                dbz_q      <= dbz_d;
`endif
            end
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
`ifdef ALU_FLAGS_EN
    assign zero        = zero_q;
    assign carry       = carry_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_alu_32_bits.sv
// Bench for alu_32_bits: directed literal checks plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_alu_32_bits;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a   = '0;
    logic [31:0] b   = '0;
    logic [2:0]  sel = '0;
    logic        in_valid = 1'b1;
    logic [31:0] out;
    logic        out_valid;
`ifdef ALU_FLAGS_EN
    logic        div_by_zero, zero, carry, overflow;
`endif

    int checks   = 0;
    int failures = 0;

    alu_32_bits #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
        ,
        .div_by_zero (div_by_zero),
        .zero        (zero),
        .carry       (carry),
        .overflow    (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain 64-bit integer arithmetic, reduced modulo 2^32.
    function automatic logic [31:0] ref_result(input int unsigned s, input logic [31:0] x, input logic [31:0] y);
        longint unsigned xx = longint'(x);
        longint unsigned yy = longint'(y);
        case (s)
            0: return ~x;
            1: return x | y;
            2: return x & y;
            3: return 32'(64'd0 - xx);
            4: return 32'(xx + yy);
            5: return 32'(xx - yy);
            6: return 32'(xx * yy);
            default: return (yy == 0) ? 32'hFFFF_FFFF : 32'(xx / yy);
        endcase
    endfunction

    function automatic logic ref_carry(input int unsigned s, input logic [31:0] x, input logic [31:0] y);
        longint unsigned xx = longint'(x);
        longint unsigned yy = longint'(y);
        if (s == 4) return (xx + yy) >= 64'h1_0000_0000;
        if (s == 5) return xx >= yy;
        return 1'b0;
    endfunction

    function automatic logic ref_ovf(input int unsigned s, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint r;
        if (s == 4) r = sx + sy;
        else if (s == 5) r = sx - sy;
        else return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    logic [31:0] m_out;
    logic        m_valid;
    logic        m_zero, m_carry, m_ovf, m_dbz;

    // Model state advances on each rising edge, DUT compared 1 time unit later.
    always @(posedge clk) begin
        if (rst) begin
            m_out = '0; m_valid = 1'b0;
            m_zero = 1'b0; m_carry = 1'b0; m_ovf = 1'b0; m_dbz = 1'b0;
        end else begin
            m_valid = in_valid;
            if (in_valid) begin
                m_out   = ref_result(int'(sel), a, b);
                m_zero  = (m_out == 0);
                m_carry = ref_carry(int'(sel), a, b);
                m_ovf   = ref_ovf(int'(sel), a, b);
                m_dbz   = (sel == 3'd7) && (b == 0);
            end
        end
        #1;
        chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("model_out", out, m_out);
`ifdef ALU_FLAGS_EN
        chk("model_flags", {28'd0, zero, carry, overflow, div_by_zero},
            {28'd0, m_zero, m_carry, m_ovf, m_dbz});
`endif
    end

    task automatic issue(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y);
        sel = s; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
    endtask

    logic [31:0] seq_exp [8] = '{32'hFFFF_FFFC, 32'h0000_0007, 32'h0000_0001, 32'hFFFF_FFFD,
                                 32'h0000_0008, 32'hFFFF_FFFE, 32'h0000_000F, 32'h0000_0000};

    initial begin
        // reset held two cycles with in_valid high
        sel = 3'd4; a = 32'd9; b = 32'd9;
        repeat (2) @(negedge clk);
        chk("reset_out", out, 32'd0);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
`ifdef ALU_FLAGS_EN
        chk("reset_flags", {28'd0, zero, carry, overflow, div_by_zero}, 32'd0);
`endif
        rst = 1'b0;

        for (int unsigned i = 0; i < 8; i++) begin
            issue(3'(i), 32'd3, 32'd5);
            chk($sformatf("seq_op%0d", i), out, seq_exp[i]);
            chk($sformatf("seq_valid%0d", i), {31'd0, out_valid}, 32'd1);
        end

        issue(3'd4, 32'hFFFF_FFFF, 32'd1);
        chk("add_wrap", out, 32'd0);
`ifdef ALU_FLAGS_EN
        chk("add_wrap_carry_zero", {30'd0, carry, zero}, 32'd3);
`endif
        issue(3'd4, 32'h7FFF_FFFF, 32'd1);
        chk("add_ovf", out, 32'h8000_0000);
`ifdef ALU_FLAGS_EN
        chk("add_ovf_flag", {31'd0, overflow}, 32'd1);
`endif
        issue(3'd6, 32'h0001_0000, 32'h0001_0000);
        chk("mul_wrap", out, 32'd0);
        issue(3'd7, 32'd100, 32'd7);
        chk("div_100_7", out, 32'd14);
        issue(3'd7, 32'd5, 32'd0);
        chk("div_by_zero", out, 32'hFFFF_FFFF);
`ifdef ALU_FLAGS_EN
        chk("div_by_zero_flag", {31'd0, div_by_zero}, 32'd1);
`endif
        issue(3'd3, 32'h8000_0000, 32'd0);
        chk("neg_min", out, 32'h8000_0000);
        issue(3'd3, 32'd0, 32'd77);
        chk("neg_zero", out, 32'd0);

        // bubble: result must hold while out_valid drops for one cycle
        issue(3'd1, 32'h00F0_0000, 32'h0000_000F);
        chk("pre_bubble", out, 32'h00F0_000F);
        in_valid = 1'b0; a = 32'hDEAD_BEEF; sel = 3'd0;
        @(negedge clk);
        chk("bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("bubble_hold", out, 32'h00F0_000F);
        issue(3'd5, 32'd10, 32'd3);
        chk("post_bubble", out, 32'd7);
        chk("post_bubble_valid", {31'd0, out_valid}, 32'd1);

        // reset wins over a concurrent issue
        sel = 3'd4; a = 32'd1; b = 32'd1; in_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("midreset_out", out, 32'd0);
        chk("midreset_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;

        for (int unsigned n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 9) < 8);
            rst      = ($urandom_range(0, 59) == 0);
            sel      = 3'($urandom_range(0, 7));
            a        = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            @(negedge clk);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
